// File: rtl/pic_rw_control.sv
// pic_rw_control -- 8259A read/write control and initialization sequencer.
//
// Qualifies the CPU strobes into active-high rd/wr enables for the data bus
// buffer, captures each written byte, and commits it one edge after the write
// strobe is released. Committed bytes walk the ICW1..ICW4 sequence and, once
// initialized, are decoded as OCW1..OCW3 into configuration registers.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cs_n, rd_n, wr_n    CPU strobes (active low)
//   a0, data_in         CPU address bit 0 and written byte
//   rd_en, wr_en        qualified read/write enables (combinational)
//   read_sel            read source: 00 IRR, 01 ISR, 10 IMR (combinational)
//   init_done           high once the ICW sequence has completed
//   ltim, sngl, ic4     ICW1 D3, D1, D0
//   vector_base         ICW2 D7:3
//   icw3, icw4          cascade byte, ICW4 D4:0
//   imr                 interrupt mask (OCW1)
//   ocw2, ocw2_stb      last OCW2 byte and its one-cycle commit pulse
//   poll_stb            one-cycle pulse on an OCW3 poll command
//   special_mask        special mask mode
module pic_rw_control (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cs_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       a0,
   input  logic [7:0] data_in,
   output logic       rd_en,
   output logic       wr_en,
   output logic [1:0] read_sel,
   output logic       init_done,
   output logic       ltim,
   output logic       sngl,
   output logic       ic4,
   output logic [4:0] vector_base,
   output logic [7:0] icw3,
   output logic [4:0] icw4,
   output logic [7:0] imr,
   output logic [7:0] ocw2,
   output logic       ocw2_stb,
   output logic       poll_stb,
   output logic       special_mask
);

   typedef enum logic [2:0] {StIdle, StIcw2, StIcw3, StIcw4, StReady} state_e;

   state_e     state_q, state_d;
   logic       wr_q, wr_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       hold_a0_q, hold_a0_d;
   logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
   logic [4:0] vector_base_q, vector_base_d;
   logic [7:0] icw3_q, icw3_d;
   logic [4:0] icw4_q, icw4_d;
   logic [7:0] imr_q, imr_d;
   logic [7:0] ocw2_q, ocw2_d;
   logic       ocw2_stb_q, ocw2_stb_d;
   logic       poll_stb_q, poll_stb_d;
   logic       special_mask_q, special_mask_d;
   logic       read_isr_q, read_isr_d;

   logic wr_act, rd_act;
   logic commit, is_icw1;

   // Write has priority when both strobes are low.
   assign wr_act = ~cs_n & ~wr_n;
   assign rd_act = ~cs_n & ~rd_n & ~wr_act;

   // Commit on the first edge that sees the write strobe gone after seeing it active.
   assign commit  = wr_q & ~wr_act;
   assign is_icw1 = ~hold_a0_q & hold_data_q[4];

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      if (commit) begin
         if (is_icw1) begin
            state_d = StIcw2;
         end else begin
            case (state_q)
               StIcw2:  state_d = !sngl_q ? StIcw3 : (ic4_q ? StIcw4 : StReady);
               StIcw3:  state_d = ic4_q ? StIcw4 : StReady;
               StIcw4:  state_d = StReady;
               StReady: state_d = StReady;
               default: state_d = StIdle;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------- capture and config
   always_comb begin
      wr_d           = wr_act;
      hold_data_d    = wr_act ? data_in : hold_data_q;
      hold_a0_d      = wr_act ? a0 : hold_a0_q;
      ltim_d         = ltim_q;
      sngl_d         = sngl_q;
      ic4_d          = ic4_q;
      vector_base_d  = vector_base_q;
      icw3_d         = icw3_q;
      icw4_d         = icw4_q;
      imr_d          = imr_q;
      ocw2_d         = ocw2_q;
      special_mask_d = special_mask_q;
      read_isr_d     = read_isr_q;
      ocw2_stb_d     = 1'b0;
      poll_stb_d     = 1'b0;

      if (commit) begin
         if (is_icw1) begin
            ltim_d         = hold_data_q[3];
            sngl_d         = hold_data_q[1];
            ic4_d          = hold_data_q[0];
            imr_d          = 8'h00;
            icw3_d         = 8'h00;
            icw4_d         = 5'h00;
            special_mask_d = 1'b0;
            read_isr_d     = 1'b0;
         end else begin
            case (state_q)
               StIcw2: vector_base_d = hold_data_q[7:3];
               StIcw3: icw3_d        = hold_data_q;
               StIcw4: icw4_d        = hold_data_q[4:0];
               StReady: begin
                  if (hold_a0_q) begin
                     imr_d = hold_data_q;
                  end else if (hold_data_q[4:3] == 2'b00) begin
                     ocw2_d     = hold_data_q;
                     ocw2_stb_d = 1'b1;
                  end else begin
                     // D4=0 here, so D4:3 is 01: OCW3.
                     if (hold_data_q[1]) read_isr_d     = hold_data_q[0];
                     if (hold_data_q[6]) special_mask_d = hold_data_q[5];
                     poll_stb_d = hold_data_q[2];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q           <= 1'b0;
         hold_data_q    <= 8'h00;
         hold_a0_q      <= 1'b0;
         ltim_q         <= 1'b0;
         sngl_q         <= 1'b0;
         ic4_q          <= 1'b0;
         vector_base_q  <= 5'h00;
         icw3_q         <= 8'h00;
         icw4_q         <= 5'h00;
         imr_q          <= 8'h00;
         ocw2_q         <= 8'h00;
         ocw2_stb_q     <= 1'b0;
         poll_stb_q     <= 1'b0;
         special_mask_q <= 1'b0;
         read_isr_q     <= 1'b0;
      end else begin
         wr_q           <= wr_d;
         hold_data_q    <= hold_data_d;
         hold_a0_q      <= hold_a0_d;
         ltim_q         <= ltim_d;
         sngl_q         <= sngl_d;
         ic4_q          <= ic4_d;
         vector_base_q  <= vector_base_d;
         icw3_q         <= icw3_d;
         icw4_q         <= icw4_d;
         imr_q          <= imr_d;
         ocw2_q         <= ocw2_d;
         ocw2_stb_q     <= ocw2_stb_d;
         poll_stb_q     <= poll_stb_d;
         special_mask_q <= special_mask_d;
         read_isr_q     <= read_isr_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      rd_en        = rd_act;
      wr_en        = wr_act;
      read_sel     = a0 ? 2'b10 : {1'b0, read_isr_q};
      init_done    = (state_q == StReady);
      ltim         = ltim_q;
      sngl         = sngl_q;
      ic4          = ic4_q;
      vector_base  = vector_base_q;
      icw3         = icw3_q;
      icw4         = icw4_q;
      imr          = imr_q;
      ocw2         = ocw2_q;
      ocw2_stb     = ocw2_stb_q;
      poll_stb     = poll_stb_q;
      special_mask = special_mask_q;
   end

endmodule

// File: tb/tb_pic_rw_control.sv
// Bench for pic_rw_control: randomized and directed CPU writes are fed through a
// behavioural model; expected post-commit outputs are queued and popped by a
// monitor that detects commits from the pin activity it observes.
module tb_pic_rw_control;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cs_n, rd_n, wr_n, a0;
   logic [7:0] data_in;
   logic       rd_en, wr_en;
   logic [1:0] read_sel;
   logic       init_done, ltim, sngl, ic4;
   logic [4:0] vector_base;
   logic [7:0] icw3;
   logic [4:0] icw4;
   logic [7:0] imr, ocw2;
   logic       ocw2_stb, poll_stb, special_mask;

   pic_rw_control dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cs_n         (cs_n),
      .rd_n         (rd_n),
      .wr_n         (wr_n),
      .a0           (a0),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .wr_en        (wr_en),
      .read_sel     (read_sel),
      .init_done    (init_done),
      .ltim         (ltim),
      .sngl         (sngl),
      .ic4          (ic4),
      .vector_base  (vector_base),
      .icw3         (icw3),
      .icw4         (icw4),
      .imr          (imr),
      .ocw2         (ocw2),
      .ocw2_stb     (ocw2_stb),
      .poll_stb     (poll_stb),
      .special_mask (special_mask)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   typedef struct packed {
      logic       init_done, ltim, sngl, ic4;
      logic [4:0] vb;
      logic [7:0] icw3;
      logic [4:0] icw4;
      logic [7:0] imr, ocw2;
      logic       ocw2_stb, poll_stb, smm, read_isr;
   } exp_t;

   exp_t exp_q[$];

   // Outstanding ICW words still owed after ICW1 (2, 3, 4).
   int         m_pending[$];
   bit         m_inited;
   logic       m_ltim, m_sngl, m_ic4, m_smm, m_read_isr;
   logic [4:0] m_vb, m_icw4;
   logic [7:0] m_icw3, m_imr, m_ocw2;

   task automatic model_reset();
      m_pending.delete();
      exp_q.delete();
      m_inited = 0;
      m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_smm = 0; m_read_isr = 0;
      m_vb = 0; m_icw4 = 0; m_icw3 = 0; m_imr = 0; m_ocw2 = 0;
   endtask

   task automatic model_write(input logic wa0, input logic [7:0] d);
      exp_t e;
      logic o2, pl;
      o2 = 0;
      pl = 0;
      if (!wa0 && d[4]) begin
         m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
         m_imr = 0; m_icw3 = 0; m_icw4 = 0; m_smm = 0; m_read_isr = 0;
         m_pending.delete();
         m_pending.push_back(2);
         if (!m_sngl) m_pending.push_back(3);
         if (m_ic4) m_pending.push_back(4);
         m_inited = 1;
      end else if (!m_inited) begin
         // ignored before ICW1
      end else if (m_pending.size() > 0) begin
         int w;
         w = m_pending.pop_front();
         if (w == 2) m_vb = d[7:3];
         else if (w == 3) m_icw3 = d;
         else m_icw4 = d[4:0];
      end else if (wa0) begin
         m_imr = d;
      end else if (!d[3]) begin
         m_ocw2 = d;
         o2 = 1;
      end else begin
         if (d[1]) m_read_isr = d[0];
         if (d[6]) m_smm = d[5];
         pl = d[2];
      end
      e.init_done = m_inited && (m_pending.size() == 0);
      e.ltim = m_ltim; e.sngl = m_sngl; e.ic4 = m_ic4;
      e.vb = m_vb; e.icw3 = m_icw3; e.icw4 = m_icw4;
      e.imr = m_imr; e.ocw2 = m_ocw2;
      e.ocw2_stb = o2; e.poll_stb = pl;
      e.smm = m_smm; e.read_isr = m_read_isr;
      exp_q.push_back(e);
   endtask

   // ---------------------------------------------------------------- monitor
   logic mon_prev   = 1'b0;
   logic mon_commit = 1'b0;

   always @(posedge clk) begin
      if (!reset_n) begin
         mon_prev   = 1'b0;
         mon_commit = 1'b0;
      end else begin
         mon_commit = mon_prev & ~(~cs_n & ~wr_n);
         mon_prev   = ~cs_n & ~wr_n;
      end
      #1;
      if (reset_n) begin
         if (mon_commit) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_commit: got commit, expected none at %0t", $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("init_done", init_done, e.init_done);
               chk("ltim", ltim, e.ltim);
               chk("sngl", sngl, e.sngl);
               chk("ic4", ic4, e.ic4);
               chk("vector_base", vector_base, e.vb);
               chk("icw3", icw3, e.icw3);
               chk("icw4", icw4, e.icw4);
               chk("imr", imr, e.imr);
               chk("ocw2", ocw2, e.ocw2);
               chk("ocw2_stb", ocw2_stb, e.ocw2_stb);
               chk("poll_stb", poll_stb, e.poll_stb);
               chk("special_mask", special_mask, e.smm);
               chk("read_sel_commit", read_sel, a0 ? 32'd2 : {31'd0, e.read_isr});
            end
         end else begin
            chk("ocw2_stb_idle", ocw2_stb, 0);
            chk("poll_stb_idle", poll_stb, 0);
         end
      end
   end

   // ---------------------------------------------------------------- drivers
   task automatic do_write(input logic wa0, input logic [7:0] d, input int act, input int gap,
                           input bit via_cs, input bit both);
      @(negedge clk);
      a0 = wa0;
      data_in = d;
      #1;
      chk("read_sel_pre", read_sel, wa0 ? 32'd2 : {31'd0, m_read_isr});
      cs_n = 0;
      wr_n = 0;
      if (both) rd_n = 0;
      #1;
      chk("wr_en_active", wr_en, 1);
      chk("rd_en_during_wr", rd_en, 0);
      model_write(wa0, d);
      repeat (act) @(negedge clk);
      if (via_cs) cs_n = 1;
      else wr_n = 1;
      rd_n = 1;
      #2;
      data_in = 8'($urandom);
      a0 = 1'($urandom);
      wr_n = 1;
      cs_n = 1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wr(input logic wa0, input logic [7:0] d);
      do_write(wa0, d, 1, 1, 0, 0);
   endtask

   task automatic do_read(input logic ra0);
      @(negedge clk);
      a0 = ra0;
      cs_n = 0;
      rd_n = 0;
      #1;
      chk("rd_en_active", rd_en, 1);
      chk("wr_en_during_rd", wr_en, 0);
      chk("read_sel_rd", read_sel, ra0 ? 32'd2 : {31'd0, m_read_isr});
      @(negedge clk);
      rd_n = 1;
      cs_n = 1;
   endtask

   task automatic deselected_toggle();
      @(negedge clk);
      cs_n = 1;
      wr_n = 0;
      rd_n = 0;
      data_in = 8'h13;
      a0 = 0;
      #1;
      chk("wr_en_desel", wr_en, 0);
      chk("rd_en_desel", rd_en, 0);
      repeat (2) @(negedge clk);
      wr_n = 1;
      rd_n = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_init_done"}, init_done, 0);
      chk({tag, "_cfg"}, {ltim, sngl, ic4, vector_base, icw3, icw4}, 0);
      chk({tag, "_imr"}, imr, 0);
      chk({tag, "_ocw2"}, ocw2, 0);
      chk({tag, "_stb"}, {ocw2_stb, poll_stb, special_mask}, 0);
      chk({tag, "_read_sel"}, read_sel, a0 ? 32'd2 : 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 0;
      cs_n = 1; rd_n = 1; wr_n = 1; a0 = 0; data_in = 0;
      model_reset();
      #1;
      chk_all_zero("reset");
      repeat (3) @(negedge clk);
      reset_n = 1;

      // Single, ICW4 required.
      wr(0, 8'h13); wr(1, 8'h20); wr(1, 8'h03);
      // Cascade init: ICW3 and ICW4.
      wr(0, 8'h11); wr(1, 8'h40); wr(1, 8'h04); wr(1, 8'h01);
      // READY commands.
      wr(1, 8'hA5); wr(0, 8'h20); wr(0, 8'h0B);
      do_read(0); do_read(1);
      wr(0, 8'h68); wr(0, 8'h0C);
      // Mid-sequence restart.
      wr(0, 8'h11); wr(1, 8'h40); wr(0, 8'h13); wr(1, 8'h08); wr(1, 8'h01);
      // Both strobes low, deselected toggles, cs_n-terminated write.
      do_write(1, 8'h3C, 1, 1, 0, 1);
      deselected_toggle();
      do_write(1, 8'hC3, 2, 1, 1, 0);

      // Asynchronous reset in READY with a write strobe held low.
      wr(1, 8'hFF);
      @(negedge clk);
      a0 = 1; data_in = 8'h55; cs_n = 0; wr_n = 0;
      @(negedge clk);
      #2;
      reset_n = 0;
      #1;
      chk_all_zero("async_reset");
      model_reset();
      @(negedge clk);
      reset_n = 1;
      model_write(1, 8'h55);
      @(negedge clk);
      wr_n = 1; cs_n = 1;
      repeat (2) @(negedge clk);
      wr(1, 8'h55);

      // Randomized traffic.
      for (int i = 0; i < 250; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) begin
            do_read(1'($urandom));
         end else if (r == 1) begin
            deselected_toggle();
         end else begin
            logic       ra0;
            logic [7:0] d;
            ra0 = 1'($urandom);
            d = 8'($urandom);
            if (!ra0 && d[4] && $urandom_range(0, 7) != 0) d[4] = 0;
            do_write(ra0, d, $urandom_range(1, 3), $urandom_range(1, 3),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
         end
      end

      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
